// File: rtl/keccak_pkg.sv
// keccak_pkg: constants, squeeze FSM state type and lane addressing shared by the Keccak
// datapath blocks (permutation, absorb, squeeze).
//   STATE_W / LANE_W / NUM_LANES : Keccak-f[1600] geometry
//   SHAKE128/256_RATE_WORDS      : rate in 64-bit lanes
//   sq_state_e                   : squeeze controller states
//   lane_off(x, y)               : bit offset of lane (x, y) inside the flat state vector
package keccak_pkg;

   localparam int unsigned STATE_W    = 1600;
   localparam int unsigned LANE_W     = 64;
   localparam int unsigned NUM_LANES  = 25;
   localparam int unsigned LANE_IDX_W = 5;

   localparam int unsigned SHAKE128_RATE_WORDS = 21;
   localparam int unsigned SHAKE256_RATE_WORDS = 17;

   typedef enum logic [1:0] {
      SqIdle,
      SqWaitSt,
      SqEmit,
      SqFin
   } sq_state_e;

   // Lane x+5y lives at bits 320y+64x +: 64.
   function automatic int unsigned lane_off(input int unsigned x, input int unsigned y);
      return 320 * y + 64 * x;
   endfunction

endpackage

// File: rtl/keccak_lane_mux.sv
// keccak_lane_mux: combinational 25:1 selector returning one 64-bit lane of a Keccak state.
//   state_i : flat 1600-bit state, lane x+5y at bits 320y+64x +: 64
//   idx_i   : linear lane index x+5y (0..24); indices 25..31 yield zero
//   lane_o  : selected lane
module keccak_lane_mux
   import keccak_pkg::*;
(
   input  logic [STATE_W-1:0]    state_i,
   input  logic [LANE_IDX_W-1:0] idx_i,
   output logic [LANE_W-1:0]     lane_o
);

   always_comb begin
      lane_o = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         if (idx_i == LANE_IDX_W'(l)) begin
            lane_o = state_i[lane_off(l % 5, l / 5) +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: SHAKE output stage. Captures a permuted state, streams its rate lanes as
// 64-bit words over valid/ready and requests further permutations until the requested number
// of words has been emitted.
//   clk, rst (sync, active-high)
//   start, num_words         : request (sampled in idle only)
//   state_in, state_valid    : permuted state from the permutation engine
//   state_ready, perm_req    : state handshake / one-cycle "permute again" pulse
//   out_data, out_valid, out_ready, out_last : word stream to the samplers
//   busy, done               : status; done pulses once per request
// Optional: define KECCAK_SQUEEZE_ABORT_EN to add the abort input, which ends a request early.
module keccak_squeeze
   import keccak_pkg::*;
#(
   parameter int unsigned RATE_WORDS = SHAKE128_RATE_WORDS,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_words,
   input  logic [STATE_W-1:0] state_in,
   input  logic               state_valid,
   output logic               state_ready,
   output logic               perm_req,
   output logic [LANE_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done
`ifdef KECCAK_SQUEEZE_ABORT_EN
   ,
   input  logic               abort
`endif
);

   localparam logic [LANE_IDX_W-1:0] LastIdx = LANE_IDX_W'(RATE_WORDS - 1);

   sq_state_e             state_q, state_d;
   logic [STATE_W-1:0]    buf_q, buf_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [LANE_IDX_W-1:0] idx_q, idx_d;
   logic                  perm_q, perm_d;
   logic                  abort_hit;

`ifdef KECCAK_SQUEEZE_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   keccak_lane_mux u_lane_mux (
      .state_i (buf_q),
      .idx_i   (idx_q),
      .lane_o  (out_data)
   );

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      rem_d       = rem_q;
      idx_d       = idx_q;
      perm_d      = 1'b0;
      state_ready = 1'b0;
      out_valid   = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         SqIdle: begin
            if (start) begin
               if (num_words != '0) begin
                  rem_d   = num_words;
                  idx_d   = '0;
                  state_d = SqWaitSt;
               end else begin
                  state_d = SqFin;
               end
            end
         end
         SqWaitSt: begin
            state_ready = 1'b1;
            if (abort_hit) begin
               state_d = SqFin;
            end else if (state_valid) begin
               buf_d   = state_in;
               idx_d   = '0;
               state_d = SqEmit;
            end
         end
         SqEmit: begin
            out_valid = 1'b1;
            // Abort wins over a same-cycle handshake: the word is treated as not taken.
            if (abort_hit) begin
               state_d = SqFin;
            end else if (out_ready) begin
               rem_d = rem_q - CNT_W'(1);
               idx_d = idx_q + LANE_IDX_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = SqFin;
               end else if (idx_q == LastIdx) begin
                  perm_d  = 1'b1;
                  state_d = SqWaitSt;
               end
            end
         end
         SqFin: begin
            done    = 1'b1;
            state_d = SqIdle;
         end
         default: state_d = SqIdle;
      endcase
   end

   assign busy     = (state_q != SqIdle);
   assign out_last = (state_q == SqEmit) && (rem_q == CNT_W'(1));
   assign perm_req = perm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SqIdle;
         buf_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         perm_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         perm_q  <= perm_d;
      end
   end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- SHAKE output stage for the Dilithium Keccak core.
- Takes a permuted 1600-bit state from the permutation datapath (theta/rho/pi/chi/iota rounds) and streams the rate portion out as 64-bit lanes over a valid/ready interface.
- When a rate block is used up and more output is still owed, it requests another permutation.
- Sits between the permutation engine and the Dilithium samplers (ExpandA, ExpandS, SampleInBall).

Parameters:
- RATE_WORDS, 21, lanes per rate block. 21 = SHAKE128 (1344 bits); 17 = SHAKE256 (1088 bits). Legal range 1..25.
- CNT_W, 16, width of the requested-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a squeeze; sampled only in IDLE.
- num_words  input  CNT_W  number of 64-bit words to emit; latched on start.
- state_in  input  1600  permuted state. Lane x+5y occupies bits 320y+64x+63 : 320y+64x.
- state_valid  input  1  state_in is valid.
- state_ready  output  1  block can accept a state.
- perm_req  output  1  one-cycle pulse: permute the current state and re-present it.
- out_data  output  64  current lane.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  qualifies the final word of the request.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the request completes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal state buffer cleared, counters 0.
- States are IDLE, WAIT_ST, EMIT, FIN.
- IDLE:
  - start with num_words != 0: latch remaining = num_words, idx = 0, go to WAIT_ST.
  - start with num_words == 0: go to FIN; no words are emitted.
- WAIT_ST:
  - state_ready = 1.
  - When state_valid = 1: capture state_in into the 1600-bit buffer, idx = 0, go to EMIT.
  - A state is accepted no earlier than the cycle after entry.
- EMIT:
  - out_valid = 1; out_data = buffer lane idx (rate lanes 0..RATE_WORDS-1, linear index x+5y).
  - out_last = (remaining == 1).
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On each handshake: remaining -= 1, idx += 1. Then exactly one of:
    - remaining reaches 0: go to FIN.
    - idx was RATE_WORDS-1 (and remaining not 0): pulse perm_req for one cycle, go to WAIT_ST.
    - otherwise: stay in EMIT and present the next lane on the next cycle.
  - Throughput is one word per cycle within a block.
  - Latency from state capture to first out_valid is 1 cycle.
- FIN: done = 1 for one cycle, then return to IDLE.
- A start asserted outside IDLE is ignored.
- state_valid asserted outside WAIT_ST is ignored; the buffer is not updated.
- Synchronous reset in any state:
  - returns to IDLE on the next edge;
  - drops out_valid and perm_req immediately at that edge;
  - discards any in-flight request.
- Capacity lanes (RATE_WORDS..24) are never output.

Optional Feature:
- Macro: KECCAK_SQUEEZE_ABORT_EN.
- When defined:
  - adds input abort (1 bit).
  - abort=1 in WAIT_ST or EMIT: next state FIN, no further out_valid or perm_req. done pulses as normal.
  - abort takes priority over a simultaneous handshake; that word counts as not transferred.
  - abort is ignored in IDLE and FIN.
- When undefined: the port does not exist and requests always run to completion.

Decomposition:
- Shared package keccak_pkg holds:
  - STATE_W = 1600, LANE_W = 64, NUM_LANES = 25;
  - SHAKE128_RATE_WORDS = 21, SHAKE256_RATE_WORDS = 17;
  - the squeeze FSM state enum;
  - a lane-index function (x,y) -> 320y+64x.
- One natural sub-module, keccak_lane_mux: a combinational 25:1 selector of a 64-bit lane by linear index, reusable by the absorb stage.

Test Plan:
- Basic read: RATE_WORDS=21, num_words=5, lane i = {8{i[7:0]}}, out_ready=1 → words 0x00..00, 0x0101..01, ..., 0x0404..04 on 5 consecutive cycles; out_last on the 5th; no perm_req; done 1 cycle later.
- Block boundary: num_words=23, RATE_WORDS=21 → perm_req pulses once after word 21.
  - Present a second state with lane i = {8{(i+0x40)[7:0]}} → words 22–23 are 0x4040..40 and 0x4141..41.
- Backpressure: num_words=3, out_ready toggling 1,0,0,1,0,1 → out_data stable while stalled; exactly 3 transfers; values match lanes 0–2.
- Zero request: start with num_words=0 → no out_valid, no state_ready, done pulse 1 cycle after start.
- Reset mid-stream: rst asserted after word 2 of 10 → out_valid=0, busy=0 after the edge; a following start with num_words=1 emits lane 0 of the newly presented state.
- Abort (KECCAK_SQUEEZE_ABORT_EN defined): abort during a stalled word 4 → word 4 never handshakes, no perm_req, done pulses once.
